// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32-M multi-cycle multiply/divide sequencer:
// funct3 encodings, FSM state encoding and the architectural special-case results.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage (master) and the mul/div sequencer (slave).
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] res;

  modport master (output start, funct3, a, b, flush, input busy, done, res);
  modport slave  (input start, funct3, a, b, flush, output busy, done, res);
endinterface

// File: rtl/muldiv_iter.sv
// One iteration of the shared datapath: a shift-add multiply step or a restoring divide step,
// both working on unsigned magnitudes held in a 2*XLEN accumulator {hi, lo}.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   sum;
  logic [XLEN-1:0] rem_low;
  logic [XLEN-1:0] rem_new;
  logic            q_bit;

  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});

    // Shifted partial remainder is {acc[2*XLEN-1], rem_low}; a set top bit already exceeds any divisor.
    rem_low = {acc[2*XLEN-2:XLEN], acc[XLEN-1]};
    q_bit   = acc[2*XLEN-1] | (rem_low >= opnd);
    rem_new = q_bit ? (rem_low - opnd) : rem_low;

    if (is_div) begin
      acc_next = {rem_new, acc[XLEN-2:0], q_bit};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32-M multi-cycle sequencer: 32-step shift-add multiply / restoring divide with sign fixup.
// Define MULDIV_FAST_MUL_EN to compute multiplies in one cycle with a 33x33 signed multiplier.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2:0]        f3_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   opnd_reg;
  logic [XLEN-1:0]   res_reg;
  logic              a_neg_reg;
  logic              b_neg_reg;
  logic              busy_reg;
  logic              done_reg;

  logic              signed_a, signed_b, a_neg, b_neg, div_op, fast_path;
  logic [XLEN-1:0]   a_mag, b_mag, fast_res;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  always_comb begin
    signed_a  = (bus.funct3 != F3_MULHU) && (bus.funct3 != F3_DIVU) && (bus.funct3 != F3_REMU);
    signed_b  = signed_a && (bus.funct3 != F3_MULHSU);
    a_neg     = signed_a & bus.a[XLEN-1];
    b_neg     = signed_b & bus.b[XLEN-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
    div_op    = bus.funct3[2];
    // signed_b within a divide means DIV/REM, the only ops with the overflow case
    fast_path = div_op && ((bus.b == '0) || (signed_b && (bus.a == INT_MIN) && (bus.b == '1)));
    fast_res  = (bus.b == '0) ? (bus.funct3[1] ? bus.a : DIV0_QUOT)
                              : (bus.funct3[1] ? '0 : INT_MIN);
  end

  always_comb begin
    prod_fix = (a_neg_reg ^ b_neg_reg) ? -acc_reg : acc_reg;
    quot_fix = (a_neg_reg ^ b_neg_reg) ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    rem_fix  = a_neg_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    case (f3_reg)
      F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = quot_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] a_ext, b_ext, prod_full;
  assign a_ext     = {{(XLEN+2){signed_a & bus.a[XLEN-1]}}, bus.a};
  assign b_ext     = {{(XLEN+2){signed_b & bus.b[XLEN-1]}}, bus.b};
  assign prod_full = a_ext * b_ext;
`endif

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .acc      (acc_reg),
    .opnd     (opnd_reg),
    .is_div   (f3_reg[2]),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      f3_reg    <= '0;
      acc_reg   <= '0;
      opnd_reg  <= '0;
      res_reg   <= '0;
      a_neg_reg <= 1'b0;
      b_neg_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (bus.start && !bus.flush) begin
            f3_reg    <= bus.funct3;
            a_neg_reg <= a_neg;
            b_neg_reg <= b_neg;
            cnt_reg   <= '0;
            acc_reg   <= {{XLEN{1'b0}}, a_mag};
            opnd_reg  <= b_mag;
            if (fast_path) begin
              res_reg   <= fast_res;
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!div_op) begin
              // Product is already signed, so FIXUP must not negate it again
              acc_reg   <= prod_full[2*XLEN-1:0];
              a_neg_reg <= 1'b0;
              b_neg_reg <= 1'b0;
              state_reg <= ST_FIXUP;
              busy_reg  <= 1'b1;
            end
`endif
            else begin
              state_reg <= ST_CALC;
              busy_reg  <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          if (bus.flush) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(XLEN-1)) state_reg <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          busy_reg <= 1'b0;
          if (bus.flush) begin
            state_reg <= ST_IDLE;
          end else begin
            res_reg   <= fix_res;
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.res  = res_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32-M vectors, randomized ops against an
// arithmetic reference model, handshake drops, flush and asynchronous reset mid-operation.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus();

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      F3_MUL:    begin p = sa * sb; return p[31:0];  end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      F3_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      F3_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Cycles from the accept edge until done is observed (0 = done right after the accept edge)
  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 == F3_DIV || f3 == F3_DIVU || f3 == F3_REM || f3 == F3_REMU) begin
      if (b == 32'd0) return 0;
      if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return 33;
    end
    return MUL_LAT;
  endfunction

  // Issues one op from IDLE and returns what was observed; inputs are scrambled after accept.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat, output int bcnt,
                        output logic done_after, output logic [31:0] r_after);
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.a      = $urandom;
    bus.b      = $urandom;
    lat  = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    r = bus.res;
    @(posedge clk); #1;
    done_after = bus.done;
    r_after    = bus.res;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.res !== 32'd0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b res=%h want busy=0 done=0 res=00000000", bus.busy, bus.done, bus.res);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: busy=%b done=%b res=%h", bus.busy, bus.done, bus.res);
  endtask

  task automatic test_directed();
    vec_t v[12];
    logic [31:0] r, r_after;
    int lat, bcnt, exp_lat;
    logic done_after;
    v[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3"};
    v[1]  = '{F3_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, "MULH 7*-3"};
    v[2]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max*max"};
    v[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, "MULHSU -1*2"};
    v[4]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "DIV -7/2"};
    v[5]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "REM -7%2"};
    v[6]  = '{F3_DIVU,   32'd100,        32'd7,         32'd14,        "DIVU 100/7"};
    v[7]  = '{F3_REMU,   32'd100,        32'd7,         32'd2,         "REMU 100%7"};
    v[8]  = '{F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, "DIVU 5/0"};
    v[9]  = '{F3_REM,    32'd5,          32'd0,         32'd5,         "REM 5%0"};
    v[10] = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "DIV min/-1"};
    v[11] = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "REM min%-1"};
    for (int i = 0; i < 12; i++) begin
      exp_lat = ref_lat(v[i].f3, v[i].a, v[i].b);
      run_op(v[i].f3, v[i].a, v[i].b, r, lat, bcnt, done_after, r_after);
      $display("directed %s: res=%h lat=%0d busy_cycles=%0d", v[i].name, r, lat, bcnt);
      checks++;
      if (r !== v[i].exp) begin
        errors++; $display("FAIL directed_res %s got %h want %h", v[i].name, r, v[i].exp);
      end
      checks++;
      if (lat !== exp_lat) begin
        errors++; $display("FAIL directed_latency %s got %0d want %0d", v[i].name, lat, exp_lat);
      end
      checks++;
      if (bcnt !== exp_lat) begin
        errors++; $display("FAIL directed_busy %s got %0d cycles want %0d", v[i].name, bcnt, exp_lat);
      end
      checks++;
      if (done_after !== 1'b0 || r_after !== v[i].exp) begin
        errors++; $display("FAIL directed_pulse_hold %s done=%b res=%h want done=0 res=%h", v[i].name, done_after, r_after, v[i].exp);
      end
    end
  endtask

  task automatic test_random_back_to_back();
    logic [2:0] f3;
    logic [31:0] a, b, r, r_after, exp;
    int lat, bcnt, exp_lat, sel;
    logic done_after;
    for (int i = 0; i < 48; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = $urandom_range(1, 15);
      if (sel == 3) a = $urandom_range(0, 100);
      exp     = ref_res(f3, a, b);
      exp_lat = ref_lat(f3, a, b);
      run_op(f3, a, b, r, lat, bcnt, done_after, r_after);
      $display("random %0d f3=%0d a=%h b=%h: res=%h want %h lat=%0d", i, f3, a, b, r, exp, lat);
      checks++;
      if (r !== exp || lat !== exp_lat) begin
        errors++;
        $display("FAIL random_op f3=%0d a=%h b=%h got res=%h lat=%0d want res=%h lat=%0d", f3, a, b, r, lat, exp, exp_lat);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] exp;
    int lat;
    exp = ref_res(F3_DIV, 32'hFFFF_FC18, 32'd7);
    bus.funct3 = F3_DIV; bus.a = 32'hFFFF_FC18; bus.b = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      bus.start = (lat == 9);
      if (lat == 9) begin bus.funct3 = F3_MUL; bus.a = 32'd3; bus.b = 32'd5; end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    $display("start_while_busy: res=%h lat=%0d", bus.res, lat);
    checks++;
    if (bus.res !== exp || lat !== 33) begin
      errors++; $display("FAIL busy_start_ignored got res=%h lat=%0d want res=%h lat=33", bus.res, lat, exp);
    end
    // start raised during the DONE cycle must also be dropped
    bus.funct3 = F3_DIVU; bus.a = 32'd9; bus.b = 32'd2; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL done_start_ignored busy=%b done=%b want busy=0 done=0", bus.busy, bus.done);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.res !== exp) begin
      errors++; $display("FAIL no_queueing busy=%b done=%b res=%h want busy=0 done=0 res=%h", bus.busy, bus.done, bus.res, exp);
    end
  endtask

  task automatic test_flush();
    logic [31:0] r, r_after, exp;
    int lat, bcnt, flush_at;
    logic done_after, seen_done;
    for (int t = 0; t < 2; t++) begin
      flush_at = (t == 0) ? 20 : 33;
      run_op(F3_DIVU, 32'd100, 32'd7, r, lat, bcnt, done_after, r_after);
      bus.funct3 = F3_DIV; bus.a = 32'hFFFF_FC18; bus.b = 32'd7; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (flush_at - 1) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++; $display("FAIL flush_idle at cycle %0d busy=%b want 0", flush_at, bus.busy);
      end
      seen_done = 1'b0;
      repeat (5) begin
        if (bus.done === 1'b1) seen_done = 1'b1;
        @(posedge clk); #1;
      end
      checks++;
      if (seen_done !== 1'b0 || bus.res !== 32'd14) begin
        errors++; $display("FAIL flush_no_result at cycle %0d done_seen=%b res=%h want done_seen=0 res=0000000e", flush_at, seen_done, bus.res);
      end
      exp = ref_res(F3_REM, 32'hFFFF_FC18, 32'd7);
      run_op(F3_REM, 32'hFFFF_FC18, 32'd7, r, lat, bcnt, done_after, r_after);
      $display("flush at cycle %0d then REM: res=%h lat=%0d", flush_at, r, lat);
      checks++;
      if (r !== exp || lat !== 33) begin
        errors++; $display("FAIL flush_then_op got res=%h lat=%0d want res=%h lat=33", r, lat, exp);
      end
    end
    // flush in IDLE blocks a simultaneous start
    bus.funct3 = F3_MUL; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL flush_blocks_start busy=%b done=%b want busy=0 done=0", bus.busy, bus.done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    logic [31:0] r, r_after, exp;
    int lat, bcnt;
    logic done_after;
    run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, r, lat, bcnt, done_after, r_after);
    bus.funct3 = F3_MUL; bus.a = 32'd123456; bus.b = 32'd789; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    $display("async_reset: busy=%b done=%b res=%h (prev res %h)", bus.busy, bus.done, bus.res, r);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.res !== 32'd0) begin
      errors++; $display("FAIL async_reset busy=%b done=%b res=%h want busy=0 done=0 res=00000000", bus.busy, bus.done, bus.res);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp = ref_res(F3_MULH, 32'h8765_4321, 32'h1234_5678);
    run_op(F3_MULH, 32'h8765_4321, 32'h1234_5678, r, lat, bcnt, done_after, r_after);
    $display("after reset MULH: res=%h lat=%0d", r, lat);
    checks++;
    if (r !== exp || lat !== MUL_LAT) begin
      errors++; $display("FAIL reset_then_op got res=%h lat=%0d want res=%h lat=%0d", r, lat, exp, MUL_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_back_to_back();
    test_start_while_busy();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
